// File: rtl/vec_elem_seq.sv
`default_nettype none
// ============================================================================
// Module   : vec_elem_seq
// Brief    : Splits a vector op into per-element micro-ops (VLEN=64) and holds
//            the vl/vtype CSRs. Optional counter: define VSEQ_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vec_elem_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_wen,
    input  logic [6:0]  cfg_vl,
    input  logic [6:0]  cfg_vtype,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [4:0]  op_vd,
    output logic        el_valid,
    input  logic        el_ready,
    output logic [6:0]  el_idx,
    output logic [2:0]  el_sew,
    output logic [4:0]  el_vreg,
    output logic [2:0]  el_boff,
    output logic        el_last,
    output logic        op_done,
    output logic        op_illegal,
    output logic [6:0]  csr_vl,
    output logic [6:0]  csr_vtype,
    output logic [15:0] perf_elem_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [6:0]  idx;
    logic [4:0]  lat_vd;
    logic [2:0]  lat_sew;
    logic [6:0]  lat_vl;
    logic        illegal;
    logic        pend_valid;
    logic [6:0]  pend_vl;
    logic [6:0]  pend_vtype;
    logic [6:0]  vreg_off;
    logic        el_hs;

    assign el_hs = el_valid && el_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        op_ready  = 1'b0;
        el_valid  = 1'b0;
        op_done   = 1'b0;
        case (state)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid)
                    state_nxt = (csr_vtype[6] && (csr_vl != 7'd0)) ? RUN : DONE;
            end
            RUN: begin
                el_valid = 1'b1;
                if (el_ready && el_last) state_nxt = DONE;
            end
            DONE: begin
                op_done   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign op_illegal = op_done && illegal;

    // vl is latched with the op so a cfg write accepted on the same edge as
    // the op cannot move the final element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= 7'd0;
            lat_vd  <= 5'd0;
            lat_sew <= 3'd0;
            lat_vl  <= 7'd0;
            illegal <= 1'b0;
        end else if (state == IDLE && op_valid) begin
            idx     <= 7'd0;
            lat_vd  <= op_vd;
            lat_sew <= csr_vtype[5:3];
            lat_vl  <= csr_vl;
            illegal <= !csr_vtype[6];
        end else if (state == RUN && el_hs && !el_last) begin
            idx <= idx + 7'd1;
        end
    end

    // Writes outside IDLE park in a one-deep buffer, released on the DONE->IDLE edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr_vl     <= 7'd0;
            csr_vtype  <= 7'd0;
            pend_valid <= 1'b0;
            pend_vl    <= 7'd0;
            pend_vtype <= 7'd0;
        end else if (state == IDLE) begin
            if (cfg_wen) begin
                csr_vl    <= cfg_vl;
                csr_vtype <= cfg_vtype;
            end
        end else if (state == DONE) begin
            if (cfg_wen) begin
                csr_vl    <= cfg_vl;
                csr_vtype <= cfg_vtype;
            end else if (pend_valid) begin
                csr_vl    <= pend_vl;
                csr_vtype <= pend_vtype;
            end
            pend_valid <= 1'b0;
        end else if (cfg_wen) begin
            pend_valid <= 1'b1;
            pend_vl    <= cfg_vl;
            pend_vtype <= cfg_vtype;
        end
    end

    always_comb begin
        vreg_off = idx;
        el_boff  = 3'd0;
        case (lat_sew)
            3'd0: begin vreg_off = idx >> 3; el_boff = idx[2:0];         end
            3'd1: begin vreg_off = idx >> 2; el_boff = {idx[1:0], 1'b0}; end
            3'd2: begin vreg_off = idx >> 1; el_boff = {idx[0], 2'b00};  end
            default: begin vreg_off = idx;   el_boff = 3'd0;             end
        endcase
    end

    assign el_vreg = lat_vd + vreg_off[4:0];
    assign el_idx  = idx;
    assign el_sew  = lat_sew;
    assign el_last = (idx == (lat_vl - 7'd1));

`ifdef VSEQ_PERF_CNT_EN
    logic [15:0] perf_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     perf_cnt <= 16'd0;
        else if (el_hs) perf_cnt <= perf_cnt + 16'd1;
    end

    assign perf_elem_cnt = perf_cnt;
`else
    assign perf_elem_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vec_elem_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_elem_seq
// Brief    : Scoreboard bench for vec_elem_seq (element and completion queues).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vec_elem_seq;

    logic        clk;
    logic        rst_n;
    logic        cfg_wen;
    logic [6:0]  cfg_vl;
    logic [6:0]  cfg_vtype;
    logic        op_valid;
    logic        op_ready;
    logic [4:0]  op_vd;
    logic        el_valid;
    logic        el_ready;
    logic [6:0]  el_idx;
    logic [2:0]  el_sew;
    logic [4:0]  el_vreg;
    logic [2:0]  el_boff;
    logic        el_last;
    logic        op_done;
    logic        op_illegal;
    logic [6:0]  csr_vl;
    logic [6:0]  csr_vtype;
    logic [15:0] perf_elem_cnt;

    vec_elem_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_wen       (cfg_wen),
        .cfg_vl        (cfg_vl),
        .cfg_vtype     (cfg_vtype),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_vd         (op_vd),
        .el_valid      (el_valid),
        .el_ready      (el_ready),
        .el_idx        (el_idx),
        .el_sew        (el_sew),
        .el_vreg       (el_vreg),
        .el_boff       (el_boff),
        .el_last       (el_last),
        .op_done       (op_done),
        .op_illegal    (op_illegal),
        .csr_vl        (csr_vl),
        .csr_vtype     (csr_vtype),
        .perf_elem_cnt (perf_elem_cnt)
    );

    typedef struct packed {
        logic [6:0] idx;
        logic [4:0] vreg;
        logic [2:0] boff;
        logic       last;
        logic [2:0] sew;
    } elem_t;

    typedef struct packed {
        logic illegal;
        logic no_elem;
    } done_t;

    elem_t exp_q[$];
    done_t done_q[$];

    int   n_tests   = 0;
    int   n_fail    = 0;
    int   exp_elems = 0;
    int   ready_mode = 0;
    logic [6:0] cur_vl = 7'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic elem_t exp_elem(input logic [4:0] vd, input int i,
                                       input int vl, input logic [2:0] sew);
        elem_t e;
        int    s;
        int    epr;
        int    vr;
        s   = (sew > 3'd3) ? 3 : int'(sew);
        epr = 8 >> s;
        vr  = int'(vd) + (i / epr);
        e.idx  = 7'(i);
        e.vreg = 5'(vr);
        e.boff = 3'((i % epr) << s);
        e.last = (i == vl - 1);
        e.sew  = sew;
        return e;
    endfunction

    // el_ready pattern: 0 = always ready, 1 = toggling, 2 = stalled
    initial begin
        el_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       el_ready = 1'b1;
                1:       el_ready = ~el_ready;
                default: el_ready = 1'b0;
            endcase
        end
    end

    logic  stall_p;
    logic  last_prev;
    logic  acc_prev;
    elem_t held;

    always @(negedge clk) begin
        elem_t e;
        done_t d;
        if (!rst_n) begin
            stall_p   = 1'b0;
            last_prev = 1'b0;
            acc_prev  = 1'b0;
        end else begin
            if (el_valid) begin
                check_eq("csr_vl_stable", {25'd0, csr_vl}, {25'd0, cur_vl});
                if (stall_p) begin
                    check_eq("hold_idx",  {25'd0, el_idx},  {25'd0, held.idx});
                    check_eq("hold_vreg", {27'd0, el_vreg}, {27'd0, held.vreg});
                    check_eq("hold_boff", {29'd0, el_boff}, {29'd0, held.boff});
                    check_eq("hold_last", {31'd0, el_last}, {31'd0, held.last});
                end
                if (el_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("extra_elem", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("el_idx",  {25'd0, el_idx},  {25'd0, e.idx});
                        check_eq("el_vreg", {27'd0, el_vreg}, {27'd0, e.vreg});
                        check_eq("el_boff", {29'd0, el_boff}, {29'd0, e.boff});
                        check_eq("el_last", {31'd0, el_last}, {31'd0, e.last});
                        check_eq("el_sew",  {29'd0, el_sew},  {29'd0, e.sew});
                    end
                    stall_p = 1'b0;
                end else begin
                    stall_p = 1'b1;
                    held    = '{idx: el_idx, vreg: el_vreg, boff: el_boff,
                                last: el_last, sew: el_sew};
                end
            end
            if (op_done) begin
                if (done_q.size() == 0) begin
                    check_eq("extra_done", 32'd1, 32'd0);
                end else begin
                    d = done_q.pop_front();
                    check_eq("op_illegal", {31'd0, op_illegal}, {31'd0, d.illegal});
                    check_eq("done_timing", {31'd0, d.no_elem ? acc_prev : last_prev}, 32'd1);
                end
            end else if (op_illegal) begin
                check_eq("illegal_wo_done", {31'd0, op_illegal}, 32'd0);
            end
            last_prev = el_valid && el_ready && el_last;
            acc_prev  = op_valid && op_ready;
        end
    end

    task automatic cfg_write(input logic [6:0] vl, input logic [6:0] vt);
        @(posedge clk); #1;
        cfg_wen = 1'b1; cfg_vl = vl; cfg_vtype = vt;
        @(posedge clk); #1;
        cfg_wen = 1'b0;
    endtask

    // Issue one op; expectations come from the vl/vtype the bench configured.
    // When wcfg is set, a cfg write is driven in the same cycle as the op.
    task automatic start_op(input logic [4:0] vd, input int vl, input logic [6:0] vt,
                            input logic wcfg, input logic [6:0] nvl, input logic [6:0] nvt);
        done_t d;
        if (vt[6]) begin
            for (int i = 0; i < vl; i++) exp_q.push_back(exp_elem(vd, i, vl, vt[5:3]));
            exp_elems += vl;
        end
        d.illegal = !vt[6];
        d.no_elem = !vt[6] || (vl == 0);
        done_q.push_back(d);
        @(posedge clk); #1;
        op_valid = 1'b1; op_vd = vd;
        if (wcfg) begin cfg_wen = 1'b1; cfg_vl = nvl; cfg_vtype = nvt; end
        @(posedge clk); #1;
        op_valid = 1'b0; cfg_wen = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk); #1;
            if (done_q.size() == 0 && exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            check_eq("timeout", 32'd1, 32'd0);
            exp_q.delete();
            done_q.delete();
        end
    endtask

    initial begin
        logic [15:0] perf_exp;
        bit          found;
        rst_n = 1'b0; cfg_wen = 1'b0; cfg_vl = '0; cfg_vtype = '0;
        op_valid = 1'b0; op_vd = '0;
        #7;
        check_eq("rst_op_ready", {31'd0, op_ready}, 32'd1);
        check_eq("rst_el_valid", {31'd0, el_valid}, 32'd0);
        check_eq("rst_op_done",  {31'd0, op_done},  32'd0);
        check_eq("rst_csr_vl",   {25'd0, csr_vl},   32'd0);
        check_eq("rst_csr_vtype",{25'd0, csr_vtype},32'd0);
        check_eq("rst_perf",     {16'd0, perf_elem_cnt}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // SEW16, vd=8, vl=5: v8 boff 0/2/4/6 then v9 boff 0
        cfg_write(7'd5, 7'h49);
        check_eq("csr_vl_load",    {25'd0, csr_vl},    32'd5);
        check_eq("csr_vtype_load", {25'd0, csr_vtype}, 32'h49);
        cur_vl = 7'd5;
        start_op(5'd8, 5, 7'h49, 1'b0, '0, '0);
        wait_done(50);

        // SEW8, vd=31, vl=8 with a toggling consumer
        cfg_write(7'd8, 7'h40);
        cur_vl = 7'd8;
        ready_mode = 1;
        start_op(5'd31, 8, 7'h40, 1'b0, '0, '0);
        wait_done(60);
        ready_mode = 0;

        // invalid vtype, then vl=0 with valid vtype
        cfg_write(7'd7, 7'h00);
        start_op(5'd3, 7, 7'h00, 1'b0, '0, '0);
        wait_done(10);
        cfg_write(7'd0, 7'h48);
        start_op(5'd3, 0, 7'h48, 1'b0, '0, '0);
        wait_done(10);

        // cfg writes during RUN are deferred; the later one wins
        cfg_write(7'd5, 7'h49);
        cur_vl = 7'd5;
        ready_mode = 2;
        start_op(5'd4, 5, 7'h49, 1'b0, '0, '0);
        cfg_write(7'd6, 7'h41);
        cfg_write(7'd2, 7'h5B);
        check_eq("run_csr_vl",    {25'd0, csr_vl},    32'd5);
        check_eq("run_csr_vtype", {25'd0, csr_vtype}, 32'h49);
        ready_mode = 0;
        wait_done(50);
        check_eq("done_csr_vl", {25'd0, csr_vl}, 32'd5);
        @(posedge clk); #1;
        check_eq("idle_csr_vl",    {25'd0, csr_vl},    32'd2);
        check_eq("idle_csr_vtype", {25'd0, csr_vtype}, 32'h5B);

        // op and cfg write together: op uses old vl=2 SEW64, vd=31 wraps to v0
        cur_vl = 7'd3;
        start_op(5'd31, 2, 7'h5B, 1'b1, 7'd3, 7'h40);
        wait_done(20);
        check_eq("same_cyc_csr_vl",    {25'd0, csr_vl},    32'd3);
        check_eq("same_cyc_csr_vtype", {25'd0, csr_vtype}, 32'h40);

`ifdef VSEQ_PERF_CNT_EN
        perf_exp = 16'(exp_elems);
`else
        perf_exp = 16'd0;
`endif
        check_eq("perf_cnt", {16'd0, perf_elem_cnt}, {16'd0, perf_exp});

        // reset while idx=3 is on offer: abandoned, no op_done
        cfg_write(7'd8, 7'h40);
        cur_vl = 7'd8;
        start_op(5'd0, 8, 7'h40, 1'b0, '0, '0);
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (el_valid && el_idx == 7'd3) begin found = 1'b1; break; end
        end
        check_eq("reach_idx3", {31'd0, found}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        done_q.delete();
        check_eq("mid_rst_el_valid", {31'd0, el_valid}, 32'd0);
        check_eq("mid_rst_csr_vl",   {25'd0, csr_vl},   32'd0);
        check_eq("mid_rst_op_done",  {31'd0, op_done},  32'd0);
        check_eq("mid_rst_op_ready", {31'd0, op_ready}, 32'd1);
        check_eq("mid_rst_perf",     {16'd0, perf_elem_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_eq("post_rst_el_valid", {31'd0, el_valid}, 32'd0);
        check_eq("post_rst_csr_vtype", {25'd0, csr_vtype}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vec_elem_seq.md
VEC_ELEM_SEQ -- requirements
Module: vec_elem_seq

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_wen  in  1  write strobe from vl_setup.
- cfg_vl  in  7  new vl.
- cfg_vtype  in  7  new vtype: bit6 valid, [5:3] SEW code, [2:0] LMUL code.
- op_valid  in  1  vector instruction offered.
- op_ready  out  1  instruction accepted when op_valid&&op_ready.
- op_vd  in  5  destination base register.
- el_valid  out  1  element micro-op offered.
- el_ready  in  1  element micro-op consumed.
- el_idx  out  7  element index.
- el_sew  out  3  SEW code of current op.
- el_vreg  out  5  physical destination register.
- el_boff  out  3  byte offset in register.
- el_last  out  1  current element is final.
- op_done  out  1  one-cycle completion pulse.
- op_illegal  out  1  qualifies op_done: op was rejected.
- csr_vl  out  7  architectural vl.
- csr_vtype  out  7  architectural vtype.
- perf_elem_cnt  out  16  element handshake count.
REQ-002 VLEN SHALL be 64 bits; elements per register EPR = 64>>(SEW+3), giving 8/4/2/1 for SEW codes 0-3.

Function
REQ-003 FSM SHALL have states IDLE, RUN and DONE; op_ready=1 only in IDLE.
REQ-004 IDLE on op accept: latch op_vd and csr_vtype[5:3]; clear idx to 0; go to RUN if csr_vtype[6]=1 and csr_vl!=0, else go to DONE with illegal flag = !csr_vtype[6].
REQ-005 RUN: el_valid=1; outputs driven from latched op; el_idx/el_vreg/el_boff/el_last held stable while el_valid && !el_ready.
REQ-006 el_vreg SHALL equal op_vd + (idx >> (3-SEW)), truncated to 5 bits (wraps past v31); el_boff SHALL equal (idx mod EPR) << SEW.
REQ-007 el_last SHALL equal (idx == csr_vl-1).
REQ-008 RUN, on el_valid&&el_ready: if el_last go to DONE, else idx increments by 1.
REQ-009 DONE SHALL last exactly one cycle with op_done=1 and op_illegal=illegal flag, then go to IDLE; op_illegal=0 whenever op_done=0.
REQ-010 vl=0 with valid vtype SHALL give DONE with op_illegal=0 and no element issued.
REQ-011 cfg_wen in IDLE SHALL load csr_vl<=cfg_vl and csr_vtype<=cfg_vtype on the next edge; an op accepted in the same cycle uses the old values.
REQ-012 cfg_wen in RUN or DONE SHALL be captured in a one-deep pending buffer (later write overwrites earlier); the pending values SHALL be applied on the edge entering IDLE.
REQ-013 csr_vl/csr_vtype SHALL never change while in RUN.

Reset
REQ-014 rst_n low SHALL immediately force: state IDLE, idx 0, csr_vl 0, csr_vtype 0, pending buffer empty, illegal flag 0, perf_elem_cnt 0.
REQ-015 During reset, el_valid=0, op_done=0, op_illegal=0 and op_ready=1; an op in flight SHALL be abandoned without op_done.

Configuration
REQ-016 Macro VSEQ_PERF_CNT_EN SHALL control the performance counter.
REQ-017 With VSEQ_PERF_CNT_EN defined, perf_elem_cnt SHALL increment by 1 on each el_valid&&el_ready and wrap from 0xFFFF to 0.
REQ-018 Without VSEQ_PERF_CNT_EN, perf_elem_cnt SHALL be constant 0 and no counter flops SHALL exist.

Verification
REQ-019 vl=5, vtype=0x49 (SEW16, x2), vd=8, el_ready=1 -> 5 elements: reg 8 with boff 0/2/4/6, then reg 9 with boff 0; el_last only on idx4; op_done 1 cycle later.
REQ-020 vl=8, vtype=0x40 (SEW8), vd=31, el_ready toggles 1/0 -> outputs held on stalls; idx7 gives reg 31, boff 7; exactly 8 handshakes.
REQ-021 vtype=0x00, op accepted -> next cycle op_done=1 and op_illegal=1; el_valid never asserted.
REQ-022 cfg_wen (vl=2, vtype=0x5B) during RUN of vl=5 -> csr_vl remains 5 until op_done, then csr_vl=2 and csr_vtype=0x5B in IDLE.
REQ-023 rst_n low at idx=3 -> el_valid=0 and csr_vl=0 at once; no op_done; with VSEQ_PERF_CNT_EN, perf_elem_cnt=0.
